// File: rtl/tap_window_buffer_if.sv
// Bus bundle for the tap window: push/flush controls, dual read request and
// the registered read results plus fill status. The master drives samples
// and read requests; the slave is the tap window itself.
interface tap_window_buffer_if #(
    parameter int dataWidth = 16,
    parameter int size      = 64
);
    localparam int address_size = $clog2(size);

    logic                      clear;
    logic                      shift;
    logic [dataWidth-1:0]      din;
    logic                      rd_en;
    logic [address_size-1:0]   address_a;
    logic [address_size-1:0]   address_b;
    logic [dataWidth-1:0]      dout_a;
    logic [dataWidth-1:0]      dout_b;
    logic                      rd_valid;
    logic                      addr_err;
    logic [address_size:0]     count;
    logic                      full;

    modport master (
        output clear, shift, din, rd_en, address_a, address_b,
        input  dout_a, dout_b, rd_valid, addr_err, count, full
    );

    modport slave (
        input  clear, shift, din, rd_en, address_a, address_b,
        output dout_a, dout_b, rd_valid, addr_err, count, full
    );
endinterface

// File: rtl/tap_window_buffer.sv
// Circular-buffer tap window holding the last `size` samples. Two read ports
// address taps by age (0 = newest) and return registered data one cycle after
// rd_en. Taps that have not been filled yet read as zero; addresses beyond the
// window read as zero and raise addr_err. `size` need not be a power of two,
// so all pointer arithmetic wraps explicitly.
module tap_window_buffer #(
    parameter int dataWidth = 16,
    parameter int size      = 64
) (
    input  logic               clk,
    input  logic               rst,
    tap_window_buffer_if.slave bus
);
    localparam int address_size = $clog2(size);

    typedef logic [address_size-1:0] addr_t;
    typedef logic [address_size:0]   cnt_t;
    typedef logic [dataWidth-1:0]    data_t;

    localparam cnt_t  SIZE_C  = cnt_t'(size);
    localparam addr_t LAST_WP = addr_t'(size - 1);

    data_t mem [size];

    addr_t wp_q,       wp_d;
    cnt_t  count_q,    count_d;
    data_t dout_a_q,   dout_a_d;
    data_t dout_b_q,   dout_b_d;
    logic  rd_valid_q, rd_valid_d;
    logic  addr_err_q, addr_err_d;

    // Physical slot of the tap k samples older than the newest one:
    // (wp - 1 - k) mod size. The sum stays below 2*size, so one conditional
    // subtraction is enough and no power-of-two masking is involved.
    function automatic addr_t tap_index(addr_t wp, addr_t k);
        cnt_t raw;
        raw = cnt_t'(wp) + SIZE_C - cnt_t'(1) - cnt_t'(k);
        if (raw >= SIZE_C) begin
            raw = raw - SIZE_C;
        end
        return addr_t'(raw);
    endfunction

    // Next-state for pointer, fill level and read results; reads see the
    // window as it stands before this cycle's push or clear.
    always_comb begin
        // NOTE: every output of this block is given a default first so no
        // path leaves a variable unassigned and a latch is never inferred.
        wp_d       = wp_q;
        count_d    = count_q;
        dout_a_d   = dout_a_q;
        dout_b_d   = dout_b_q;
        rd_valid_d = 1'b0;
        addr_err_d = 1'b0;

        if (bus.clear) begin
            wp_d    = '0;
            count_d = '0;
        end else if (bus.shift) begin
            wp_d = (wp_q == LAST_WP) ? '0 : wp_q + addr_t'(1);
            if (count_q != SIZE_C) begin
                count_d = count_q + cnt_t'(1);
            end
        end

        if (bus.rd_en) begin
            rd_valid_d = 1'b1;
            addr_err_d = (cnt_t'(bus.address_a) >= SIZE_C) ||
                         (cnt_t'(bus.address_b) >= SIZE_C);
            // count never exceeds size, so k < count also proves k is in range.
            dout_a_d = (cnt_t'(bus.address_a) < count_q) ?
                       mem[tap_index(wp_q, bus.address_a)] : '0;
            dout_b_d = (cnt_t'(bus.address_b) < count_q) ?
                       mem[tap_index(wp_q, bus.address_b)] : '0;
        end
    end

    // Control and output registers; reset discards any read in flight.
    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so every flop
        // samples the pre-edge values regardless of statement order.
        if (rst) begin
            wp_q       <= '0;
            count_q    <= '0;
            dout_a_q   <= '0;
            dout_b_q   <= '0;
            rd_valid_q <= 1'b0;
            addr_err_q <= 1'b0;
        end else begin
            wp_q       <= wp_d;
            count_q    <= count_d;
            dout_a_q   <= dout_a_d;
            dout_b_q   <= dout_b_d;
            rd_valid_q <= rd_valid_d;
            addr_err_q <= addr_err_d;
        end
    end

    // Sample storage write port.
    always_ff @(posedge clk) begin
        // NOTE: the sample array is deliberately not reset; count gates every
        // read, so stale contents are never visible and the array can map to RAM.
        if (!rst && bus.shift && !bus.clear) begin
            mem[wp_q] <= bus.din;
        end
    end

    assign bus.dout_a   = dout_a_q;
    assign bus.dout_b   = dout_b_q;
    assign bus.rd_valid = rd_valid_q;
    assign bus.addr_err = addr_err_q;
    assign bus.count    = count_q;
    assign bus.full     = (count_q == SIZE_C);
endmodule

// File: tb/tb_tap_window_buffer.sv
// Testbench for tap_window_buffer with a non-power-of-two window (size 5).
// The reference model keeps the window as a queue, newest sample first.
module tb_tap_window_buffer;
    localparam int DW   = 16;
    localparam int SIZE = 5;
    localparam int AW   = $clog2(SIZE);

    logic clk = 1'b0;
    logic rst = 1'b1;

    tap_window_buffer_if #(.dataWidth(DW), .size(SIZE)) bus ();

    tap_window_buffer #(.dataWidth(DW), .size(SIZE)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int n_total = 0;
    int n_bad   = 0;
    int step_no = 0;

    logic [DW-1:0] window [$];
    logic [DW-1:0] exp_a = '0;
    logic [DW-1:0] exp_b = '0;
    logic          exp_v = 1'b0;
    logic          exp_e = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s step=%0d got=%0h exp=%0h", tag, step_no, got, exp);
        end
    endtask

    function automatic logic [DW-1:0] model_read(input int k);
        if (k >= SIZE || k >= window.size()) return '0;
        return window[k];
    endfunction

    // One clock: drive inputs, advance the model, compare every output.
    task automatic step(input bit r, input bit cl, input bit sh, input logic [DW-1:0] d,
                        input bit re, input int a, input int b);
        rst           = r;
        bus.clear     = cl;
        bus.shift     = sh;
        bus.din       = d;
        bus.rd_en     = re;
        bus.address_a = AW'(a);
        bus.address_b = AW'(b);
        @(posedge clk);
        #1;
        step_no++;
        if (r) begin
            window.delete();
            exp_a = '0;
            exp_b = '0;
            exp_v = 1'b0;
            exp_e = 1'b0;
        end else begin
            if (re) begin
                exp_a = model_read(a);
                exp_b = model_read(b);
                exp_v = 1'b1;
                exp_e = (a >= SIZE) || (b >= SIZE);
            end else begin
                exp_v = 1'b0;
                exp_e = 1'b0;
            end
            if (cl) begin
                window.delete();
            end else if (sh) begin
                window.push_front(d);
                if (window.size() > SIZE) void'(window.pop_back());
            end
        end
        check("dout_a",   32'(bus.dout_a),   32'(exp_a));
        check("dout_b",   32'(bus.dout_b),   32'(exp_b));
        check("rd_valid", 32'(bus.rd_valid), 32'(exp_v));
        check("addr_err", 32'(bus.addr_err), 32'(exp_e));
        check("count",    32'(bus.count),    32'(window.size()));
        check("full",     32'(bus.full),     32'(window.size() == SIZE));
    endtask

    task automatic push(input logic [DW-1:0] d);
        step(0, 0, 1, d, 0, 0, 0);
    endtask

    task automatic do_reset();
        step(1, 0, 0, '0, 0, 0, 0);
    endtask

    initial begin
        bus.clear     = 1'b0;
        bus.shift     = 1'b0;
        bus.din       = '0;
        bus.rd_en     = 1'b0;
        bus.address_a = '0;
        bus.address_b = '0;

        do_reset();
        do_reset();

        // Basic ages: newest and oldest of three.
        for (int i = 1; i <= 3; i++) push(DW'(i));
        step(0, 0, 0, '0, 1, 0, 2);

        // Wrap plus overwrite: after 1..7 the window is 7,6,5,4,3.
        do_reset();
        for (int i = 1; i <= 7; i++) push(DW'(i));
        step(0, 0, 0, '0, 1, 0, 4);

        // Unfilled tap reads zero without an address error.
        do_reset();
        push(16'd10);
        push(16'd20);
        step(0, 0, 0, '0, 1, 1, 3);

        // Out-of-range address, then idle cycle holds data and drops pulses.
        step(0, 0, 0, '0, 1, 6, 0);
        step(0, 0, 0, '0, 0, 0, 0);
        step(0, 0, 0, '0, 1, 7, 5);

        // Clear beats shift; same-cycle read sees the pre-clear window.
        do_reset();
        for (int i = 1; i <= 4; i++) push(DW'(i));
        step(0, 1, 1, 16'd9, 1, 0, 1);
        step(0, 0, 0, '0, 1, 0, 0);

        // Read during write returns the old newest sample.
        do_reset();
        push(16'd1);
        push(16'd2);
        step(0, 0, 1, 16'd5, 1, 0, 1);
        step(0, 0, 0, '0, 1, 0, 2);

        // Reset mid-stream with a read launched discards the read.
        push(16'd7);
        step(0, 0, 1, 16'd8, 1, 0, 1);
        step(1, 0, 1, 16'd3, 1, 0, 1);
        step(0, 0, 0, '0, 1, 0, 0);

        // Randomized traffic over every address value the port can carry.
        for (int i = 0; i < 400; i++) begin
            bit r, cl, sh, re;
            r  = ($urandom_range(0, 99) < 2);
            cl = ($urandom_range(0, 99) < 6);
            sh = ($urandom_range(0, 99) < 70);
            re = ($urandom_range(0, 99) < 60);
            step(r, cl, sh, DW'($urandom), re,
                 int'($urandom_range(0, (1 << AW) - 1)),
                 int'($urandom_range(0, (1 << AW) - 1)));
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule
